mem_access_sequencer: RTL

// - Multi-cycle load/store controller between core datapath and a word-wide data memory.
// - Accepts one access per instruction: opcode-decoded write flag, funct3 size code, byte address.
// - Drives a valid/ready memory handshake; sb/sh use read-modify-write.
// - Holds the core via stall until done; sign/zero-extends loads; flags misaligned or illegal accesses.

---
 rtl/mem_seq_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_access_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types for the load/store sequencer: FSM state encoding, funct3 size codes,
// and the alignment/legality rule used when an access is accepted.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR    = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  // Halves must sit on an even byte, words on a multiple of four.
  function automatic logic is_legal(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      SIZE_B, SIZE_BU: is_legal = 1'b1;
      SIZE_H, SIZE_HU: is_legal = ~lane[0];
      SIZE_W:          is_legal = (lane == 2'b00);
      default:         is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts and extends a loaded byte/half from a memory
// word, and merges store data into an old word for sub-word stores.
module mem_lane_align
  import mem_seq_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (size)
      SIZE_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      SIZE_BU: load_data = {24'h0, byte_sel};
      SIZE_H:  load_data = {{16{half_sel[15]}}, half_sel};
      SIZE_HU: load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_data = word;
    case (size)
      SIZE_B, SIZE_BU: begin
        case (lane)
          2'd0:    store_data[7:0]   = wdata[7:0];
          2'd1:    store_data[15:8]  = wdata[7:0];
          2'd2:    store_data[23:16] = wdata[7:0];
          default: store_data[31:24] = wdata[7:0];
        endcase
      end
      SIZE_H, SIZE_HU: begin
        if (lane[1]) store_data[31:16] = wdata[15:0];
        else         store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store controller between the core and a word-wide data memory.
// Optional handshake watchdog is enabled by defining MEM_TIMEOUT_EN.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        timeout,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  state_dbg
);

  // Handshake: mem_valid is a pure function of state (RD/WR), so it and the
  // req-derived mem_addr/mem_wdata/mem_write hold steady until mem_valid &&
  // mem_ready is seen at a rising edge, and drop at once on async reset.

  state_t      state, state_nxt;
  logic [31:0] rdata_q, merge_q;
  logic [31:0] load_ext, merge_word;
  logic        legal, is_word, xfer, expired, timeout_flag;

  assign legal   = is_legal(req_size, req_addr[1:0]);
  assign is_word = (req_size == SIZE_W);
  assign xfer    = mem_valid && mem_ready;

  mem_lane_align u_align (
    .word       (mem_rdata),
    .wdata      (req_wdata),
    .size       (req_size),
    .lane       (req_addr[1:0]),
    .load_data  (load_ext),
    .store_data (merge_word)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
  logic             in_xfer_state;

  assign in_xfer_state = (state == RD) || (state == WR);
  // Fires on the last permitted wait cycle so FAULT follows after TIMEOUT_CYCLES waits.
  assign expired = in_xfer_state && !mem_ready &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expired;
      if ((state_nxt != state) && ((state_nxt == RD) || (state_nxt == WR)))
        wait_cnt <= '0;
      else if (in_xfer_state && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign expired      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!legal)                      state_nxt = FAULT;
          else if (!req_write || !is_word) state_nxt = RD;
          else                             state_nxt = WR;
        end
      end
      RD: begin
        if (expired)   state_nxt = FAULT;
        else if (xfer) state_nxt = req_write ? WR : DONE;
      end
      WR: begin
        if (expired)   state_nxt = FAULT;
        else if (xfer) state_nxt = DONE;
      end
      DONE, FAULT: state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      merge_q <= '0;
    end else if ((state == RD) && xfer) begin
      if (req_write) merge_q <= merge_word;
      else           rdata_q <= load_ext;
    end
  end

  always_comb begin
    mem_valid = (state == RD) || (state == WR);
    mem_write = (state == WR);
    mem_addr  = {req_addr[31:2], 2'b00};
    mem_wdata = is_word ? req_wdata : merge_q;
    done      = (state == DONE) || (state == FAULT);
    fault     = (state == FAULT);
    timeout   = (state == FAULT) && timeout_flag;
    stall     = req_valid && (state != DONE) && (state != FAULT);
    rdata     = rdata_q;
    state_dbg = state;
  end

endmodule
